// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch
// and load/store. It runs one transaction at a time: grant, one-cycle access,
// fixed-latency wait, then a one-cycle response to the owner.
// Optional build macro ARB_ROUND_ROBIN_EN: ties alternate between requesters
// instead of fixed data priority.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_gnt,
  output logic                    if_rvalid,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_be,
  output logic                    d_gnt,
  output logic                    d_rvalid,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    busy
);

  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t                 state_q;
  logic                   owner_d_q;   // 1 = data requester owns the transaction
  logic                   we_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic [BE_W-1:0]        be_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [DATA_WIDTH-1:0]  rdata_q;
  logic                   mem_en_q;
  logic                   mem_we_q;
  logic                   if_rvalid_q;
  logic                   d_rvalid_q;
  logic                   busy_q;
`ifdef ARB_ROUND_ROBIN_EN
  logic                   last_d_q;    // 1 = data requester was granted last
`endif

  // Grant decode: only in IDLE, combinational from state and requests.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (state_q == IDLE) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (if_req && d_req) begin
        if (last_d_q) if_gnt = 1'b1;
        else          d_gnt  = 1'b1;
      end else begin
        if_gnt = if_req;
        d_gnt  = d_req;
      end
`else
      d_gnt  = d_req;
      if_gnt = if_req && !d_req;
`endif
    end
  end

  // Transaction sequencer with registered memory strobes and responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_d_q   <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      busy_q      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_q    <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (if_gnt || d_gnt) begin
            owner_d_q <= d_gnt;
            we_q      <= d_gnt && d_we;
            addr_q    <= d_gnt ? d_addr : if_addr;
            wdata_q   <= d_gnt ? d_wdata : '0;
            be_q      <= d_gnt ? d_be : '1;
            mem_en_q  <= 1'b1;
            mem_we_q  <= d_gnt && d_we;
            busy_q    <= 1'b1;
            state_q   <= ACCESS;
`ifdef ARB_ROUND_ROBIN_EN
            last_d_q  <= d_gnt;
`endif
          end
        end
        ACCESS: begin
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
          if (we_q) begin
            // Store: acknowledge right away with zero data.
            rdata_q     <= '0;
            if_rvalid_q <= !owner_d_q;
            d_rvalid_q  <= owner_d_q;
            state_q     <= RESP;
          end else begin
            cnt_q   <= CNT_W'(MEM_LATENCY - 1);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            rdata_q     <= mem_rdata;
            if_rvalid_q <= !owner_d_q;
            d_rvalid_q  <= owner_d_q;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          if_rvalid_q <= 1'b0;
          d_rvalid_q  <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign if_rdata  = rdata_q;
  assign d_rdata   = rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;
  assign busy      = busy_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencing controller sharing the single-ported unified memory between the instruction-fetch requester and the load/store requester of the RISC-V core. It accepts one request at a time, drives the memory port for exactly one cycle, waits the fixed memory read latency, and returns the response to the owning requester. It sits between the PC/fetch stage, the data-memory interface, and the memory macro. While it is busy, the core's stall logic holds the PC.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data word width; byte-enable width is DATA_WIDTH/8
- MEM_LATENCY, 2, cycles from mem_en to valid mem_rdata; legal range 1..15

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held high until if_gnt
- if_addr  in  ADDR_WIDTH  fetch address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  DATA_WIDTH  fetched instruction word
- d_req  in  1  data request; held high until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  store data
- d_be  in  DATA_WIDTH/8  store byte enables
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  one-cycle pulse: load data valid, or store acknowledged
- d_rdata  out  DATA_WIDTH  load data; 0 on store ack
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_be  out  DATA_WIDTH/8  memory byte enables
- mem_rdata  in  DATA_WIDTH  memory read data
- busy  out  1  high whenever state ≠ IDLE

## Operation
- FSM states: IDLE, ACCESS, WAIT, RESP.
- **IDLE**
  - If any request is pending, the arbiter picks a winner and asserts that requester's gnt combinationally in the same cycle.
  - It latches owner, we, addr, wdata and be (be is forced all-ones for fetch). Next state is ACCESS.
- **ACCESS**
  - mem_en = 1 for exactly one cycle, driven from the latched fields.
  - Store: next state is RESP.
  - Load/fetch: the latency counter is loaded with MEM_LATENCY-1, and next state is WAIT.
- **WAIT**
  - The counter decrements each cycle.
  - When the counter is 0, mem_rdata is captured into the response register, and next state is RESP.
- **RESP**
  - The owner's rvalid pulses for one cycle with the response register (0 for a store). Next state is IDLE.
- Arbitration when both requests are high in IDLE: d_req wins (fixed priority).
- If a requester drops req before its gnt, no access occurs. Requester inputs are ignored outside IDLE.
- The gnt signals are never both high. At most one transaction is in flight.
- Outside ACCESS, mem_en and mem_we are 0. mem_addr, mem_wdata and mem_be reflect the latched fields at all times.

## Timing
- Reset values: state = IDLE; all gnt, rvalid, mem_en, mem_we and busy = 0; all address, data and be registers = 0; latency counter = 0; last-owner = data.
- Reset asserted mid-transaction: the FSM returns to IDLE on that edge. The in-flight response is discarded, and no rvalid is issued.
- Read with grant at cycle T:
  - mem_en at T+1.
  - mem_rdata is sampled at the end of cycle T+1+MEM_LATENCY.
  - rvalid at T+2+MEM_LATENCY.
  - Next grant is possible at T+3+MEM_LATENCY.
- Store with grant at cycle T:
  - mem_en and mem_we at T+1.
  - d_rvalid (ack) at T+2.
  - Next grant is possible at T+3.
- busy is high from T+1 through the RESP cycle inclusive.
- rvalid is registered-state decoded. gnt is combinational from state and the req inputs.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - On a tie in IDLE, the requester that is not the last owner wins.
  - The last-owner register updates on every grant; its reset value is data, so the first tie goes to fetch.
  - A requester alone always wins regardless of last owner.
- ARB_ROUND_ROBIN_EN not defined: fixed data priority, and the last-owner register is absent.

## Test plan
- Reset then single fetch, if_addr=0x0000_0010, MEM_LATENCY=2, mem_rdata=0x0050_0093:
  - if_gnt at T, mem_en at T+1, if_rvalid at T+4 with if_rdata=0x0050_0093.
- Store, d_addr=0x100, d_wdata=0xDEAD_BEEF, d_be=0xF:
  - mem_we=1 with mem_addr=0x100 at T+1, then d_rvalid at T+2 with d_rdata=0.
- Simultaneous if_req and d_req held for 3 transactions:
  - Fixed priority: grant order D,D,D.
  - ARB_ROUND_ROBIN_EN: grant order I,D,I.
- Fetch granted, rst=1 at T+2 for one cycle:
  - No if_rvalid follows; busy=0 and state IDLE at T+3.
  - A new if_req is then granted normally.
- MEM_LATENCY=1 load, mem_rdata=0x1234_5678:
  - d_rvalid exactly at T+3 with d_rdata=0x1234_5678.
  - req pulsed during busy is never granted, and mem_en is high exactly one cycle per transaction.
